// File: rtl/spi_frm_pkg.sv
// Shared SPI frame definitions: frame geometry, CRC-8 polynomial, receiver FSM
// states and the 16-to-8 CRC function used by both slave and master sides.
package spi_frm_pkg;

    localparam int         FRM_BITS = 24;
    localparam logic [7:0] CRC_POLY = 8'h07;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACT  = 2'd1,
        ST_CHK  = 2'd2
    } frm_state_t;

    // CRC-8, init 0, no reflection, no final XOR, MSB of the payload first.
    function automatic logic [7:0] crc8_16(input logic [15:0] d);
        logic [7:0] c;
        c = '0;
        for (int i = 15; i >= 0; i--) begin
            if (c[7] ^ d[i]) begin
                c = {c[6:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/spi_slv_frame_rx_if.sv
// Pin and result bundle of the SPI frame receiver; slave is the device side,
// master is whatever drives the SPI pins and consumes the frame results.
interface spi_slv_frame_rx_if;

    logic        i_sclk;
    logic        i_csb;
    logic        i_mosi;
    logic        o_miso;
    logic        o_miso_oe;
    logic [15:0] i_rsp_data;
    logic        o_frm_vld;
    logic [7:0]  o_cmd;
    logic [7:0]  o_data;
    logic        o_crc_err;
    logic        o_len_err;
    logic [7:0]  o_frm_cnt;

    modport slave (
        input  i_sclk, i_csb, i_mosi, i_rsp_data,
        output o_miso, o_miso_oe, o_frm_vld, o_cmd, o_data,
               o_crc_err, o_len_err, o_frm_cnt
    );

    modport master (
        output i_sclk, i_csb, i_mosi, i_rsp_data,
        input  o_miso, o_miso_oe, o_frm_vld, o_cmd, o_data,
               o_crc_err, o_len_err, o_frm_cnt
    );

endinterface

// File: rtl/crc16to8_parallel.sv
// Single-cycle CRC-8 (poly 0x07) over a 16-bit word, MSB first.
module crc16to8_parallel
    import spi_frm_pkg::*;
(
    input  logic [15:0] i_data,
    output logic [7:0]  o_crc
);

    assign o_crc = crc8_16(i_data);

endmodule

// File: rtl/spi_slv_sync.sv
// Multi-flop synchroniser for one asynchronous SPI line, with rise/fall
// decode taken from the last synchroniser stage and one extra history flop.
module spi_slv_sync #(
    parameter int   SYNC_STG = 2,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STG:0] sync_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= {(SYNC_STG + 1){IDLE_LVL}};
        end else begin
            sync_q <= {sync_q[SYNC_STG-1:0], i_d};
        end
    end

    assign o_lvl  = sync_q[SYNC_STG-1];
    assign o_rise = sync_q[SYNC_STG-1] & ~sync_q[SYNC_STG];
    assign o_fall = ~sync_q[SYNC_STG-1] & sync_q[SYNC_STG];

endmodule

// File: rtl/spi_slv_frame_rx.sv
// SPI slave receiver for the {cmd, data, crc8} command frame, oversampled in
// the i_clk domain, with a simultaneous {rsp, crc8(rsp)} reply on MISO.
module spi_slv_frame_rx
    import spi_frm_pkg::*;
#(
    parameter int SYNC_STG  = 2,
    parameter int FRM_BITS  = spi_frm_pkg::FRM_BITS,
    parameter int BIT_CNT_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    spi_slv_frame_rx_if.slave bus
);

    frm_state_t             state_q;
    frm_state_t             state_d;
    logic [FRM_BITS-1:0]    rx_sh;
    logic [FRM_BITS-1:0]    tx_sh;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   sclk_lvl, sclk_rise, sclk_fall;
    logic                   csb_lvl, csb_rise, csb_fall;
    logic                   mosi_lvl, mosi_rise, mosi_fall;
    logic [7:0]             crc_rx;
    logic [7:0]             crc_tx;
    logic                   crc_ok;
    logic                   unused_sync;

    spi_slv_sync #(.SYNC_STG(SYNC_STG), .IDLE_LVL(1'b0)) u_sync_sclk (
        .i_clk (i_clk), .i_rst (i_rst), .i_d (bus.i_sclk),
        .o_lvl (sclk_lvl), .o_rise (sclk_rise), .o_fall (sclk_fall)
    );

    spi_slv_sync #(.SYNC_STG(SYNC_STG), .IDLE_LVL(1'b1)) u_sync_csb (
        .i_clk (i_clk), .i_rst (i_rst), .i_d (bus.i_csb),
        .o_lvl (csb_lvl), .o_rise (csb_rise), .o_fall (csb_fall)
    );

    spi_slv_sync #(.SYNC_STG(SYNC_STG), .IDLE_LVL(1'b0)) u_sync_mosi (
        .i_clk (i_clk), .i_rst (i_rst), .i_d (bus.i_mosi),
        .o_lvl (mosi_lvl), .o_rise (mosi_rise), .o_fall (mosi_fall)
    );

    // Only the edges of SCLK/CSB and the level of MOSI steer the frame logic.
    assign unused_sync = ^{sclk_lvl, csb_lvl, mosi_rise, mosi_fall};

    crc16to8_parallel u_crc_rx (
        .i_data (rx_sh[FRM_BITS-1:8]),
        .o_crc  (crc_rx)
    );

    crc16to8_parallel u_crc_tx (
        .i_data (bus.i_rsp_data),
        .o_crc  (crc_tx)
    );

    assign crc_ok = (rx_sh[7:0] == crc_rx);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (csb_fall) state_d = ST_ACT;
            ST_ACT:  if (csb_rise) state_d = ST_CHK;
            ST_CHK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Result pulses are registered in the CHK cycle so they line up with the
    // updated o_cmd/o_data/o_frm_cnt on the following cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_sh         <= '0;
            tx_sh         <= '0;
            bit_cnt       <= '0;
            bus.o_cmd     <= '0;
            bus.o_data    <= '0;
            bus.o_frm_cnt <= '0;
            bus.o_frm_vld <= 1'b0;
            bus.o_crc_err <= 1'b0;
            bus.o_len_err <= 1'b0;
        end else begin
            bus.o_frm_vld <= 1'b0;
            bus.o_crc_err <= 1'b0;
            bus.o_len_err <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (csb_fall) begin
                        bit_cnt <= '0;
                        tx_sh   <= {bus.i_rsp_data, crc_tx};
                    end
                end
                ST_ACT: begin
                    // An SCLK edge coinciding with CSB release is dropped.
                    if (!csb_rise) begin
                        if (sclk_rise) begin
                            rx_sh <= {rx_sh[FRM_BITS-2:0], mosi_lvl};
                            if (bit_cnt != '1) begin
                                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                            end
                        end
                        if (sclk_fall) begin
                            tx_sh <= {tx_sh[FRM_BITS-2:0], 1'b0};
                        end
                    end
                end
                ST_CHK: begin
                    if (bit_cnt == BIT_CNT_W'(FRM_BITS)) begin
                        if (crc_ok) begin
                            bus.o_frm_vld <= 1'b1;
                            bus.o_cmd     <= rx_sh[FRM_BITS-1 -: 8];
                            bus.o_data    <= rx_sh[FRM_BITS-9 -: 8];
                            bus.o_frm_cnt <= bus.o_frm_cnt + 8'd1;
                        end else begin
                            bus.o_crc_err <= 1'b1;
                        end
                    end else if (bit_cnt != '0) begin
                        bus.o_len_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.o_miso    = (state_q == ST_ACT) & tx_sh[FRM_BITS-1];
    assign bus.o_miso_oe = (state_q == ST_ACT);

endmodule

// File: tb/tb_spi_slv_frame_rx.sv
// Scoreboard bench for spi_slv_frame_rx: two instances (SYNC_STG 2 and 3)
// receive identical SPI traffic; monitors pop expected results on each pulse.
module tb_spi_slv_frame_rx;

    localparam int         SYNC_A = 2;
    localparam int         SYNC_B = 3;
    localparam logic [1:0] K_VLD  = 2'd1;
    localparam logic [1:0] K_CRC  = 2'd2;
    localparam logic [1:0] K_LEN  = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] cmd;
        logic [7:0] data;
        logic [7:0] cnt;
    } exp_t;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        sclk = 1'b0;
    logic        csb  = 1'b1;
    logic        mosi = 1'b0;
    logic [15:0] rsp  = 16'h0000;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        q_a[$];
    exp_t        q_b[$];
    exp_t        ea, eb;
    logic [7:0]  m_cmd = 8'h00;
    logic [7:0]  m_data = 8'h00;
    logic [7:0]  m_cnt = 8'h00;
    logic [23:0] miso_cap;

    always #5 clk = ~clk;

    spi_slv_frame_rx_if bus_a ();
    spi_slv_frame_rx_if bus_b ();

    assign bus_a.i_sclk     = sclk;
    assign bus_a.i_csb      = csb;
    assign bus_a.i_mosi     = mosi;
    assign bus_a.i_rsp_data = rsp;
    assign bus_b.i_sclk     = sclk;
    assign bus_b.i_csb      = csb;
    assign bus_b.i_mosi     = mosi;
    assign bus_b.i_rsp_data = rsp;

    spi_slv_frame_rx #(.SYNC_STG(SYNC_A), .FRM_BITS(24), .BIT_CNT_W(5)) dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_a.slave)
    );

    spi_slv_frame_rx #(.SYNC_STG(SYNC_B), .FRM_BITS(24), .BIT_CNT_W(5)) dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_b.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference CRC by polynomial long division of {d, 8'h00} by 0x107.
    function automatic logic [7:0] crc_ref(input logic [15:0] d);
        logic [23:0] r;
        r = {d, 8'h00};
        for (int i = 23; i >= 8; i--) begin
            if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
        end
        return r[7:0];
    endfunction

    function automatic logic [1:0] kind_of(input logic v, input logic c, input logic l);
        case ({v, c, l})
            3'b100:  return K_VLD;
            3'b010:  return K_CRC;
            3'b001:  return K_LEN;
            default: return 2'd0;
        endcase
    endfunction

    task automatic expect_result(input logic [1:0] k, input logic [23:0] frm);
        exp_t e;
        if (k == K_VLD) begin
            m_cmd  = frm[23:16];
            m_data = frm[15:8];
            m_cnt  = m_cnt + 8'd1;
        end
        e.kind = k;
        e.cmd  = m_cmd;
        e.data = m_data;
        e.cnt  = m_cnt;
        q_a.push_back(e);
        q_b.push_back(e);
    endtask

    task automatic mon_check(input string tag, input exp_t e, input logic [1:0] k,
                             input logic [7:0] cmd, input logic [7:0] data, input logic [7:0] cnt);
        check({tag, "_kind"}, 32'(k), 32'(e.kind));
        check({tag, "_cmd"},  32'(cmd), 32'(e.cmd));
        check({tag, "_data"}, 32'(data), 32'(e.data));
        check({tag, "_cnt"},  32'(cnt), 32'(e.cnt));
    endtask

    always @(posedge clk) begin
        #1;
        if (bus_a.o_frm_vld || bus_a.o_crc_err || bus_a.o_len_err) begin
            if (q_a.size() == 0) begin
                check("a_spurious_pulse", 32'({bus_a.o_frm_vld, bus_a.o_crc_err, bus_a.o_len_err}), 32'd0);
            end else begin
                ea = q_a.pop_front();
                mon_check("a", ea, kind_of(bus_a.o_frm_vld, bus_a.o_crc_err, bus_a.o_len_err),
                          bus_a.o_cmd, bus_a.o_data, bus_a.o_frm_cnt);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (bus_b.o_frm_vld || bus_b.o_crc_err || bus_b.o_len_err) begin
            if (q_b.size() == 0) begin
                check("b_spurious_pulse", 32'({bus_b.o_frm_vld, bus_b.o_crc_err, bus_b.o_len_err}), 32'd0);
            end else begin
                eb = q_b.pop_front();
                mon_check("b", eb, kind_of(bus_b.o_frm_vld, bus_b.o_crc_err, bus_b.o_len_err),
                          bus_b.o_cmd, bus_b.o_data, bus_b.o_frm_cnt);
            end
        end
    end

    // Drives one CSB-low window of nbits SCLK periods (half = i_clk cycles per
    // SCLK phase). chg_at >= 0 swaps i_rsp_data mid-frame; rst_at >= 0 aborts
    // the frame with a reset after that many SCLKs.
    task automatic send_frame(input logic [23:0] frm, input int nbits, input int half,
                              input logic exp_pulse, input int chg_at, input int rst_at);
        int lat_a;
        int lat_b;
        csb = 1'b0;
        repeat (4) @(negedge clk);
        miso_cap = '0;
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                repeat (3) @(negedge clk);
                csb  = 1'b1;
                mosi = 1'b0;
                repeat (4) @(negedge clk);
                check("rst_frm_vld", 32'(bus_a.o_frm_vld), 32'd0);
                check("rst_frm_cnt", 32'(bus_a.o_frm_cnt), 32'd0);
                check("rst_miso_oe", 32'(bus_a.o_miso_oe), 32'd0);
                check("rst_miso",    32'(bus_a.o_miso), 32'd0);
                m_cmd  = 8'h00;
                m_data = 8'h00;
                m_cnt  = 8'h00;
                rst = 1'b0;
                repeat (4) @(negedge clk);
                return;
            end
            if (i == chg_at) rsp = 16'hFFFF;
            if (i == 12 && chg_at >= 0) check("miso_oe_active", 32'(bus_a.o_miso_oe), 32'd1);
            mosi = (i < 24) ? frm[23 - i] : 1'b0;
            repeat (half) @(negedge clk);
            miso_cap = {miso_cap[22:0], bus_a.o_miso};
            sclk = 1'b1;
            repeat (half) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (3) @(negedge clk);
        csb  = 1'b1;
        mosi = 1'b0;
        // k = 1 is the first posedge sampling CSB high.
        lat_a = 0;
        lat_b = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (lat_a == 0 && (bus_a.o_frm_vld || bus_a.o_crc_err || bus_a.o_len_err)) lat_a = k;
            if (lat_b == 0 && (bus_b.o_frm_vld || bus_b.o_crc_err || bus_b.o_len_err)) lat_b = k;
        end
        @(negedge clk);
        if (exp_pulse) begin
            check("latency_a", 32'(lat_a), 32'(SYNC_A + 2));
            check("latency_b", 32'(lat_b), 32'(SYNC_B + 2));
        end
        check("pending_a", 32'(q_a.size()), 32'd0);
        check("pending_b", 32'(q_b.size()), 32'd0);
    endtask

    initial begin
        logic [23:0] f;
        logic [7:0]  b8;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_frm_vld", 32'(bus_a.o_frm_vld), 32'd0);
        check("reset_crc_err", 32'(bus_a.o_crc_err), 32'd0);
        check("reset_len_err", 32'(bus_a.o_len_err), 32'd0);
        check("reset_cmd",     32'(bus_a.o_cmd), 32'd0);
        check("reset_data",    32'(bus_a.o_data), 32'd0);
        check("reset_frm_cnt", 32'(bus_a.o_frm_cnt), 32'd0);
        check("reset_miso",    32'(bus_a.o_miso), 32'd0);
        check("reset_miso_oe", 32'(bus_a.o_miso_oe), 32'd0);
        check("reset_b_cnt",   32'(bus_b.o_frm_cnt), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Good frame: cmd 01, data 00, crc 15.
        expect_result(K_VLD, 24'h010015);
        send_frame(24'h010015, 24, 4, 1'b1, -1, -1);
        check("t1_cmd", 32'(bus_a.o_cmd), 32'h01);
        check("t1_data", 32'(bus_a.o_data), 32'h00);
        check("t1_cnt", 32'(bus_a.o_frm_cnt), 32'd1);

        // Bad CRC leaves the held outputs alone.
        expect_result(K_CRC, 24'h010001);
        send_frame(24'h010001, 24, 4, 1'b1, -1, -1);
        check("t2_cmd", 32'(bus_a.o_cmd), 32'h01);
        check("t2_data", 32'(bus_a.o_data), 32'h00);
        check("t2_cnt", 32'(bus_a.o_frm_cnt), 32'd1);

        // Short, long (saturating past 24) and empty selects.
        expect_result(K_LEN, 24'h010015);
        send_frame(24'h010015, 23, 4, 1'b1, -1, -1);
        expect_result(K_LEN, 24'h010015);
        send_frame(24'h010015, 25, 4, 1'b1, -1, -1);
        send_frame(24'h010015, 0, 4, 1'b0, -1, -1);
        check("t3_cnt", 32'(bus_a.o_frm_cnt), 32'd1);

        // MISO reply of rsp 0x0100 is 0x010015 even though rsp changes mid-frame.
        rsp = 16'h0100;
        f = {16'h0203, crc_ref(16'h0203)};
        expect_result(K_VLD, f);
        send_frame(f, 24, 4, 1'b1, 8, -1);
        check("t4_miso_bits", 32'(miso_cap), 32'h010015);
        check("t4_miso_oe_idle", 32'(bus_a.o_miso_oe), 32'd0);
        check("t4_cnt", 32'(bus_a.o_frm_cnt), 32'd2);
        rsp = 16'h0000;

        // Reset after 12 SCLKs, then an all-zero frame.
        send_frame(24'h000000, 24, 4, 1'b0, -1, 12);
        expect_result(K_VLD, 24'h000000);
        send_frame(24'h000000, 24, 4, 1'b1, -1, -1);
        check("t5_cmd", 32'(bus_a.o_cmd), 32'h00);
        check("t5_data", 32'(bus_a.o_data), 32'h00);
        check("t5_cnt", 32'(bus_a.o_frm_cnt), 32'd1);

        // 256 good frames from a fresh reset wrap the counter back to 0.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_cmd  = 8'h00;
        m_data = 8'h00;
        m_cnt  = 8'h00;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            b8 = 8'(i);
            f  = {b8, ~b8, crc_ref({b8, ~b8})};
            expect_result(K_VLD, f);
            send_frame(f, 24, 2, 1'b1, -1, -1);
        end
        check("t6_wrap_a", 32'(bus_a.o_frm_cnt), 32'd0);
        check("t6_wrap_b", 32'(bus_b.o_frm_cnt), 32'd0);
        check("t6_last_cmd", 32'(bus_a.o_cmd), 32'hFF);
        check("t6_last_data", 32'(bus_a.o_data), 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

endmodule
